// File: rtl/ecg_rpeak_detector.sv
// ecg_rpeak_detector: streaming R-peak detector with an adaptive amplitude threshold.
// It takes filtered ECG samples and, for each beat, emits a one-cycle event that
// carries the peak amplitude and the RR interval counted in accepted samples.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   data_in     signed filtered sample, accepted when in_valid is high
//   in_valid    sample qualifier (no backpressure)
//   peak_valid  one-cycle beat event
//   peak_amp    signed beat maximum, held between events
//   rr_interval samples between this and the previous beat maximum (0 on first, saturating)
//   threshold   current adaptive threshold, never below THRESH_MIN
module ecg_rpeak_detector #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RR_W        = 12,
  parameter int          THRESH_INIT = 2000,
  parameter int          THRESH_MIN  = 500,
  parameter int unsigned REFRACTORY  = 72,
  parameter int unsigned MAX_WIDTH   = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     in_valid,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [RR_W-1:0]   rr_interval,
  output logic signed [DATA_W-1:0] threshold
);

  localparam int unsigned WidthW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned RefW   = $clog2(REFRACTORY + 1);

  localparam logic signed [DATA_W-1:0] ThrInit  = DATA_W'(THRESH_INIT);
  localparam logic        [DATA_W-1:0] ThrMin   = DATA_W'(THRESH_MIN);
  localparam logic        [WidthW-1:0] MaxWidth = WidthW'(MAX_WIDTH);
  localparam logic        [RefW-1:0]   RefInit  = RefW'(REFRACTORY);

  typedef enum logic [1:0] {StSearch, StRising, StRefract} state_e;

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   max_q, max_d;
  logic        [RR_W-1:0]     cand_q, cand_d;
  logic        [WidthW-1:0]   width_q, width_d;
  logic        [RefW-1:0]     ref_cnt_q, ref_cnt_d;
  logic        [RR_W-1:0]     since_peak_q, since_peak_d;
  logic                       first_done_q, first_done_d;
  logic                       peak_valid_q, peak_valid_d;
  logic signed [DATA_W-1:0]   peak_amp_q, peak_amp_d;
  logic        [RR_W-1:0]     rr_q, rr_d;
  logic signed [DATA_W-1:0]   thr_q, thr_d;

  logic                       above_thr;
  logic                       new_max;
  logic signed [DATA_W-1:0]   max_sel;
  logic        [RR_W-1:0]     cand_sel;
  logic        [RR_W-1:0]     since_inc;
  logic        [WidthW-1:0]   width_inc;
  logic        [DATA_W+1:0]   thr_sum;
  logic        [DATA_W-1:0]   thr_div;
  logic        [DATA_W-1:0]   thr_clamped;

  // Negative samples are never above a positive threshold, so a signed compare suffices.
  assign above_thr = data_in > thr_q;
  assign new_max   = data_in > max_q;   // strict: on a tie the earlier maximum is kept
  assign max_sel   = new_max ? data_in : max_q;
  assign cand_sel  = new_max ? since_peak_q : cand_q;
  assign since_inc = (since_peak_q == '1) ? since_peak_q : since_peak_q + RR_W'(1);
  assign width_inc = width_q + WidthW'(1);

  // Both operands are positive when this is used, so an unsigned sum cannot overflow.
  assign thr_sum     = ({2'b00, thr_q} << 1) + {2'b00, thr_q} + {3'b000, max_sel[DATA_W-1:1]};
  assign thr_div     = DATA_W'(thr_sum >> 2);
  assign thr_clamped = (thr_div < ThrMin) ? ThrMin : thr_div;

  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    cand_d       = cand_q;
    width_d      = width_q;
    ref_cnt_d    = ref_cnt_q;
    since_peak_d = since_peak_q;
    first_done_d = first_done_q;
    peak_valid_d = 1'b0;
    peak_amp_d   = peak_amp_q;
    rr_d         = rr_q;
    thr_d        = thr_q;

    if (in_valid) begin
      since_peak_d = since_inc;
      unique case (state_q)
        StSearch: begin
          if (above_thr) begin
            state_d = StRising;
            max_d   = data_in;
            cand_d  = since_peak_q;
            width_d = WidthW'(1);
          end
        end
        StRising: begin
          max_d   = max_sel;
          cand_d  = cand_sel;
          width_d = width_inc;
          // A width-limit hit and a below-threshold sample fall into the same single confirm.
          if (!above_thr || width_inc >= MaxWidth) begin
            peak_valid_d = 1'b1;
            peak_amp_d   = max_sel;
            rr_d         = first_done_q ? cand_sel : '0;
            first_done_d = 1'b1;
            // Re-base the counter on the beat maximum; a saturated count stays saturated.
            since_peak_d = (since_peak_q == '1) ? since_peak_q : since_inc - cand_sel;
            thr_d        = thr_clamped;
            ref_cnt_d    = RefInit;
            state_d      = StRefract;
          end
        end
        StRefract: begin
          ref_cnt_d = ref_cnt_q - RefW'(1);
          if (ref_cnt_q == RefW'(1)) begin
            state_d = StSearch;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StSearch;
      max_q        <= '0;
      cand_q       <= '0;
      width_q      <= '0;
      ref_cnt_q    <= '0;
      since_peak_q <= '0;
      first_done_q <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_amp_q   <= '0;
      rr_q         <= '0;
      thr_q        <= ThrInit;
    end else begin
      state_q      <= state_d;
      max_q        <= max_d;
      cand_q       <= cand_d;
      width_q      <= width_d;
      ref_cnt_q    <= ref_cnt_d;
      since_peak_q <= since_peak_d;
      first_done_q <= first_done_d;
      peak_valid_q <= peak_valid_d;
      peak_amp_q   <= peak_amp_d;
      rr_q         <= rr_d;
      thr_q        <= thr_d;
    end
  end

  assign peak_valid  = peak_valid_q;
  assign peak_amp    = peak_amp_q;
  assign rr_interval = rr_q;
  assign threshold   = thr_q;

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// tb_ecg_rpeak_detector: directed bench for ecg_rpeak_detector.
// A second instance with THRESH_MIN = 1500 exercises the threshold clamp; it shares the
// sample stream but only sees in_valid while clamp_sel is set.
module tb_ecg_rpeak_detector;

  logic               clk;
  logic               reset;
  logic signed [15:0] data_in;
  logic               in_valid;
  logic               clamp_sel;
  logic               main_valid;
  logic               clamp_valid;

  logic               pv_m;
  logic signed [15:0] amp_m;
  logic        [11:0] rr_m;
  logic signed [15:0] thr_m;

  logic               pv_c;
  logic signed [15:0] amp_c;
  logic        [11:0] rr_c;
  logic signed [15:0] thr_c;

  int checks;
  int errors;

  assign main_valid  = in_valid & ~clamp_sel;
  assign clamp_valid = in_valid & clamp_sel;

  ecg_rpeak_detector dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .in_valid    (main_valid),
    .peak_valid  (pv_m),
    .peak_amp    (amp_m),
    .rr_interval (rr_m),
    .threshold   (thr_m)
  );

  ecg_rpeak_detector #(
    .THRESH_MIN (1500)
  ) dut_clamp (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .in_valid    (clamp_valid),
    .peak_valid  (pv_c),
    .peak_amp    (amp_c),
    .rr_interval (rr_c),
    .threshold   (thr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted sample; outputs are stable 1 time unit after the accepting edge on return.
  task automatic push(input logic signed [15:0] d);
    @(negedge clk);
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_n(input logic signed [15:0] d, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      push(d);
      if (pv_m || pv_c) pulses++;
    end
  endtask

  // Same as push_n but with idle cycles inserted; idle cycles must not count as samples.
  task automatic push_n_gaps(input logic signed [15:0] d, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      push(d);
      if (pv_m || pv_c) pulses++;
      if (i % 7 == 3) begin
        repeat (3) @(posedge clk);
        #1;
        if (pv_m || pv_c) pulses++;
      end
    end
  endtask

  task automatic test_reset;
    int p;
    reset     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    clamp_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL rst_pv: got %b expected 0", pv_m); end
    checks++; if (amp_m !== 16'sd0) begin errors++; $display("FAIL rst_amp: got %0d expected 0", amp_m); end
    checks++; if (rr_m !== 12'd0) begin errors++; $display("FAIL rst_rr: got %0d expected 0", rr_m); end
    checks++; if (thr_m !== 16'sd2000) begin errors++; $display("FAIL rst_thr: got %0d expected 2000", thr_m); end
    @(negedge clk);
    reset = 1'b1;
    push_n(16'sd0, 20, p);
    checks++; if (p != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", p); end
    checks++; if (thr_m !== 16'sd2000) begin errors++; $display("FAIL idle_thr: got %0d expected 2000", thr_m); end
    checks++; if (rr_m !== 12'd0) begin errors++; $display("FAIL idle_rr: got %0d expected 0", rr_m); end
  endtask

  // Maximum 5000 lands on stream index 23 (20 idle zeros precede), confirm on index 25.
  task automatic test_first_peak;
    int p;
    p = 0;
    push(16'sd0);    if (pv_m) p++;
    push(16'sd1000); if (pv_m) p++;
    push(16'sd3000); if (pv_m) p++;
    push(16'sd5000); if (pv_m) p++;
    push(16'sd4000); if (pv_m) p++;
    checks++; if (p != 0) begin errors++; $display("FAIL first_early: got %0d pulses expected 0", p); end
    push(16'sd1000);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL first_pv: got %b expected 1", pv_m); end
    checks++; if (amp_m !== 16'sd5000) begin errors++; $display("FAIL first_amp: got %0d expected 5000", amp_m); end
    checks++; if (rr_m !== 12'd0) begin errors++; $display("FAIL first_rr: got %0d expected 0", rr_m); end
    checks++; if (thr_m !== 16'sd2125) begin errors++; $display("FAIL first_thr: got %0d expected 2125", thr_m); end
    push(16'sd0);    // index 26
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL first_pulse_len: got %b expected 0", pv_m); end
    checks++; if (amp_m !== 16'sd5000) begin errors++; $display("FAIL first_amp_hold: got %0d expected 5000", amp_m); end
  endtask

  // Second maximum at index 323 = 23 + 300; zeros fill indices 27..321.
  task automatic test_rr_interval;
    int p;
    push_n_gaps(16'sd0, 295, p);
    push(16'sd3000); if (pv_m) p++;
    push(16'sd5000); if (pv_m) p++;
    push(16'sd4000); if (pv_m) p++;
    checks++; if (p != 0) begin errors++; $display("FAIL rr_early: got %0d pulses expected 0", p); end
    push(16'sd1000); // index 325, confirm
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL rr_pv: got %b expected 1", pv_m); end
    checks++; if (rr_m !== 12'd300) begin errors++; $display("FAIL rr_value: got %0d expected 300", rr_m); end
    checks++; if (thr_m !== 16'sd2218) begin errors++; $display("FAIL rr_thr: got %0d expected 2218", thr_m); end
  endtask

  task automatic test_refractory;
    int p;
    int q;
    // Pulse at the 10th sample after confirm lies inside the 72-sample refractory window.
    push_n(16'sd0, 9, p);
    push(16'sd4000); if (pv_m) p++;
    push(16'sd8000); if (pv_m) p++;
    push(16'sd4000); if (pv_m) p++;
    push(16'sd0);    if (pv_m) p++;
    push_n(16'sd0, 66, q);
    p += q;
    checks++; if (p != 0) begin errors++; $display("FAIL refr_ignored: got %0d pulses expected 0", p); end
    // Pulse at the 80th sample after confirm (index 405), maximum at index 406.
    push(16'sd4000);
    push(16'sd8000);
    push(16'sd4000);
    push(16'sd0);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL refr_pv: got %b expected 1", pv_m); end
    checks++; if (amp_m !== 16'sd8000) begin errors++; $display("FAIL refr_amp: got %0d expected 8000", amp_m); end
    checks++; if (rr_m !== 12'd83) begin errors++; $display("FAIL refr_rr: got %0d expected 83", rr_m); end
    checks++; if (thr_m !== 16'sd2663) begin errors++; $display("FAIL refr_thr: got %0d expected 2663", thr_m); end
  endtask

  task automatic test_width_limit;
    int p;
    int q;
    push_n(16'sd0, 72, p);
    push_n(16'sd3000, 35, q);
    p += q;
    checks++; if (p != 0) begin errors++; $display("FAIL width_early: got %0d pulses expected 0", p); end
    push(16'sd3000);  // 36th above-threshold sample
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL width_pv: got %b expected 1", pv_m); end
    checks++; if (amp_m !== 16'sd3000) begin errors++; $display("FAIL width_amp: got %0d expected 3000", amp_m); end
    checks++; if (thr_m !== 16'sd2372) begin errors++; $display("FAIL width_thr: got %0d expected 2372", thr_m); end
    push_n(16'sd3000, 14, p);
    push_n(16'sd0, 58, q);
    p += q;
    checks++; if (p != 0) begin errors++; $display("FAIL width_tail: got %0d pulses expected 0", p); end
    // Width limit and a below-threshold sample on the same (36th) sample.
    push_n(16'sd3000, 35, p);
    push(16'sd0);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL coinc_pv: got %b expected 1", pv_m); end
    checks++; if (thr_m !== 16'sd2154) begin errors++; $display("FAIL coinc_thr: got %0d expected 2154", thr_m); end
    push(16'sd0);
    if (pv_m) p++;
    checks++; if (p != 0) begin errors++; $display("FAIL coinc_single: got %0d extra pulses expected 0", p); end
  endtask

  task automatic test_clamp;
    int p;
    int n;
    logic signed [15:0] peaks [4];
    logic signed [15:0] exp_thr [4];
    peaks   = '{16'sd2100, 16'sd1800, 16'sd1600, 16'sd1550};
    exp_thr = '{16'sd1762, 16'sd1546, 16'sd1500, 16'sd1500};
    clamp_sel = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      push(peaks[k]);
      if (pv_c) n++;
      push(16'sd0);
      checks++;
      if (pv_c !== 1'b1) begin
        errors++; $display("FAIL clamp_pv%0d: got %b expected 1", k, pv_c);
      end
      checks++;
      if (thr_c !== exp_thr[k]) begin
        errors++; $display("FAIL clamp_thr%0d: got %0d expected %0d", k, thr_c, exp_thr[k]);
      end
      push_n(16'sd0, 72, p);
      n += p;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL clamp_extra: got %0d pulses expected 0", n); end
    checks++; if (thr_m !== 16'sd2154) begin errors++; $display("FAIL clamp_main_hold: got %0d expected 2154", thr_m); end
    clamp_sel = 1'b0;
  endtask

  task automatic test_reset_mid_peak;
    int p;
    // One refractory sample was consumed at the end of test_width_limit.
    push_n(16'sd0, 71, p);
    push(16'sd3000);
    push(16'sd4000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL mid_pv: got %b expected 0", pv_m); end
    checks++; if (amp_m !== 16'sd0) begin errors++; $display("FAIL mid_amp: got %0d expected 0", amp_m); end
    checks++; if (rr_m !== 12'd0) begin errors++; $display("FAIL mid_rr: got %0d expected 0", rr_m); end
    checks++; if (thr_m !== 16'sd2000) begin errors++; $display("FAIL mid_thr: got %0d expected 2000", thr_m); end
    @(negedge clk);
    reset = 1'b1;
    push(16'sd0);
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL mid_no_pulse: got %b expected 0", pv_m); end
    push(16'sd3000);
    push(16'sd5000);
    push(16'sd1000);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL post_pv: got %b expected 1", pv_m); end
    checks++; if (rr_m !== 12'd0) begin errors++; $display("FAIL post_rr: got %0d expected 0", rr_m); end
    checks++; if (thr_m !== 16'sd2125) begin errors++; $display("FAIL post_thr: got %0d expected 2125", thr_m); end
  endtask

  task automatic test_saturation;
    int p;
    push_n(16'sd0, 5000, p);
    checks++; if (p != 0) begin errors++; $display("FAIL sat_idle: got %0d pulses expected 0", p); end
    push(16'sd3000);
    push(16'sd5000);
    push(16'sd1000);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL sat_pv: got %b expected 1", pv_m); end
    checks++; if (rr_m !== 12'd4095) begin errors++; $display("FAIL sat_rr: got %0d expected 4095", rr_m); end
    checks++; if (thr_m !== 16'sd2218) begin errors++; $display("FAIL sat_thr: got %0d expected 2218", thr_m); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_peak();
    test_rr_interval();
    test_refractory();
    test_width_limit();
    test_clamp();
    test_reset_mid_peak();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecg_rpeak_detector.md
# ecg_rpeak_detector

Streaming R-peak detector that sits directly downstream of the 8th-order FIR stage (`fir_8th`). It consumes the filtered 16-bit ECG samples and tracks an adaptive amplitude threshold. For each detected beat it emits a one-cycle event carrying the peak amplitude and the RR interval, counted in samples.

## Interface

**Parameters**
- `DATA_W`, default 16: sample width; must match FIR `filtered_output`.
- `RR_W`, default 12: RR-interval / sample-counter width.
- `THRESH_INIT`, default 2000: threshold after reset (signed, positive).
- `THRESH_MIN`, default 500: lower clamp on the adaptive threshold; must be > 0.
- `REFRACTORY`, default 72: samples ignored after a confirmed peak (200 ms at 360 Hz); must be ≥ 1.
- `MAX_WIDTH`, default 36: maximum samples spent in RISING before a forced confirm.

**Ports** (clock and reset first)
- `clk`, in, 1: single system clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset; assert at 0, release synchronously to `clk`.
- `data_in`, in, DATA_W: signed filtered sample.
- `in_valid`, in, 1: `data_in` is accepted on an edge where this is high. There is no backpressure.
- `peak_valid`, out, 1: one-cycle event pulse.
- `peak_amp`, out, DATA_W: signed maximum sample of the detected beat. Valid with `peak_valid`; holds otherwise.
- `rr_interval`, out, RR_W: samples between this peak max and the previous peak max. It is 0 for the first peak after reset and saturates at 2^RR_W−1.
- `threshold`, out, DATA_W: current threshold (signed, always ≥ THRESH_MIN).

## Operation

- **State machine:** SEARCH → RISING → REFRACT → SEARCH. State advances only on edges with `in_valid` = 1. With `in_valid` = 0, all state, counters and outputs (except `peak_valid`) hold.
- **SEARCH:**
  - If `data_in` > `threshold` (signed, strict), go to RISING.
  - On entry: `max` = `data_in`, `cand` = `since_peak`, `width` = 1.
- **RISING:**
  - If `data_in` > `max` (strict), update `max` = `data_in` and `cand` = `since_peak`. On a tie, the first max wins.
  - `width` increments on every accepted sample.
- **Confirm:** on the sample where `data_in` ≤ `threshold`, or where `width` reaches MAX_WIDTH:
  - Pulse `peak_valid`.
  - `peak_amp` = `max`.
  - `rr_interval` = `cand` if `first_done` is set, else 0; then set `first_done`.
  - `since_peak` = `since_peak` − `cand`, saturation-preserving: if `since_peak` was saturated it stays saturated.
  - Update the threshold (rule below).
  - Load `ref_cnt` = REFRACTORY and go to REFRACT.
- **REFRACT:**
  - Every accepted sample decrements `ref_cnt`; samples are not compared against the threshold.
  - On the sample that brings `ref_cnt` to 0, go to SEARCH. That sample is not itself tested.
- **`since_peak`:** RR_W-bit counter that increments on every accepted sample in all states, including the confirming sample, and saturates at all-ones.
- **Threshold update:**
  - Compute in 2+DATA_W bits, unsigned (`max` > `threshold` > 0 is guaranteed): `thr_next` = (3·`threshold` + (`max` >> 1)) >> 2, floor.
  - Clamp: if `thr_next` < THRESH_MIN, use THRESH_MIN.
  - The result always fits DATA_W because it is ≤ `max`.
- **Negative samples:** never exceed the threshold. In RISING they confirm the peak.
- **Simultaneous events:** if the `width` limit and a below-threshold sample coincide, exactly one confirm occurs.

## Timing

- **Reset values** (asynchronous, while `reset` = 0):
  - Outputs: `peak_valid` = 0, `peak_amp` = 0, `rr_interval` = 0, `threshold` = THRESH_INIT.
  - Internal: state = SEARCH, `since_peak` = 0, `first_done` = 0, `max`/`cand`/`width`/`ref_cnt` = 0.
- **Latency:** `peak_valid`, `peak_amp`, `rr_interval` and the new `threshold` are all registered. They become visible after the edge that accepts the confirming sample, and `peak_valid` is high for exactly one cycle.
- **Throughput:** one sample per cycle (`in_valid` may be held high continuously). The FIR bench's two-cycle spacing is also legal.
- **Reset mid-operation:** reset asserted in RISING or REFRACT aborts with no `peak_valid` pulse. After release, the block starts in SEARCH with `first_done` = 0.

## Test plan

1. **Reset and idle**
   - Stimulus: hold `reset` = 0, then release; feed 20 samples of 0.
   - Required: `peak_valid` never rises, `threshold` = 2000, `rr_interval` = 0.
2. **First peak**
   - Stimulus: samples 0, 1000, 3000, 5000, 4000, 1000.
   - Required: `peak_valid` pulses once, after the edge accepting the final 1000; `peak_amp` = 5000, `rr_interval` = 0, `threshold` = (6000 + 2500) >> 2 = 2125.
3. **RR interval**
   - Stimulus: second pulse (peak 5000) whose max arrives 300 accepted samples after the first max, with `in_valid` gaps inserted.
   - Required: `rr_interval` = 300 (gaps not counted); `threshold` = (6375 + 2500) >> 2 = 2218.
4. **Refractory**
   - Stimulus: a pulse of 8000 starting 10 samples after confirm.
   - Required: no detection.
   - Stimulus: the same pulse starting 80 samples after confirm.
   - Required: detected, `peak_amp` = 8000.
5. **Width limit and clamp**
   - Stimulus: constant 3000 for 50 samples.
   - Required: forced confirm on the 36th RISING sample, `peak_amp` = 3000.
   - Clamp: with THRESH_MIN = 1500 and a small-peak sequence, `threshold` never drops below 1500.
6. **Reset mid-peak and saturation**
   - Stimulus: assert `reset` during RISING.
   - Required: no pulse, all outputs return to their reset values immediately.
   - Stimulus: feed 5000 samples of 0, then a peak.
   - Required: `rr_interval` = 4095 (saturated).
